// File: rtl/uart_msg_pkg.sv
// Shared types and constants for the preset-message UART scheduler.
//   FRAME_LEN / IDX_W : bytes per message frame and byte-index width
//   ID_W / BYTE_W     : message id and UART byte widths
//   HDR0/HDR1/CHK_XOR : fixed frame header bytes and checksum mask
//   state_e           : sequencing FSM states
//   cmd_req_t         : one arbitrated command request (valid + id)
//   frame_byte()      : byte idx of the frame for a given id
package uart_msg_pkg;

  localparam int unsigned FRAME_LEN = 4;
  localparam int unsigned IDX_W     = $clog2(FRAME_LEN);
  localparam int unsigned ID_W      = 4;
  localparam int unsigned BYTE_W    = 8;

  localparam logic [BYTE_W-1:0] HDR0    = 8'hA5;
  localparam logic [BYTE_W-1:0] HDR1    = 8'h5A;
  localparam logic [BYTE_W-1:0] CHK_XOR = 8'hFF;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD      = 2'd1,
    SEND      = 2'd2,
    WAIT_DONE = 2'd3
  } state_e;

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } cmd_req_t;

  // Frame layout: HDR0, HDR1, id, ~id (as CHK_XOR ^ id)
  function automatic logic [BYTE_W-1:0] frame_byte(input logic [ID_W-1:0]  id,
                                                   input logic [IDX_W-1:0] idx);
    logic [BYTE_W-1:0] w_id_byte;
    w_id_byte = BYTE_W'(id);
    case (idx)
      IDX_W'(0): frame_byte = HDR0;
      IDX_W'(1): frame_byte = HDR1;
      IDX_W'(2): frame_byte = w_id_byte;
      default:   frame_byte = CHK_XOR ^ w_id_byte;
    endcase
  endfunction

endpackage

// File: rtl/uart_msg_sched_fifo.sv
// msg_cmd_fifo: small synchronous command queue with two write ports.
//   i_flush              : clear pointers and count (wins over writes/pop)
//   i_wr0_en/i_wr0_data  : first write port
//   i_wr1_en/i_wr1_data  : second write port, honoured only with i_wr0_en
//   i_pop                : drop head entry
//   o_head_c             : head entry (combinational read)
//   o_count              : registered occupancy
// Caller guarantees no overflow/underflow.
module msg_cmd_fifo #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_flush,
  input  logic                     i_wr0_en,
  input  logic [DATA_W-1:0]        i_wr0_data,
  input  logic                     i_wr1_en,
  input  logic [DATA_W-1:0]        i_wr1_data,
  input  logic                     i_pop,
  output logic [DATA_W-1:0]        o_head_c,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              w_wr1;

  assign w_wr1    = i_wr0_en & i_wr1_en;
  assign o_head_c = r_mem[r_rd_ptr];
  assign o_count  = r_count;

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_wr0_en) r_wr_ptr <= r_wr_ptr + PTR_W'(1) + PTR_W'(w_wr1);
      if (i_pop)    r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= r_count + CNT_W'(i_wr0_en) + CNT_W'(w_wr1) - CNT_W'(i_pop);
    end
  end

  // Storage; contents are don't-care while count is zero, so no reset
  always_ff @(posedge clk) begin
    if (!i_flush) begin
      if (i_wr0_en) r_mem[r_wr_ptr]              <= i_wr0_data;
      if (w_wr1)    r_mem[r_wr_ptr + PTR_W'(1)]  <= i_wr1_data;
    end
  end

endmodule

// File: rtl/uart_msg_sched.sv
// uart_msg_sched: arbitrates message commands from two sources into a
// queue and plays each one out as a 4-byte frame through a byte UART TX
// core using a tx_start / tx_done handshake.
//   req_a_*/req_b_* : command strobes and ids; prio_b picks the winner
//   abort           : flush queue, finish the byte in flight, drop the rest
//   tx_busy         : core status, informational only
//   tx_done         : core end-of-byte pulse, the only sequencing event
//   tx_start/tx_data: byte send strobe and byte (held until tx_done)
//   sched_busy      : frame in progress or commands pending
//   last_id         : id of the last fully sent frame
//   ovf / bad_id    : pulses for requests dropped (queue full / bad id)
module uart_msg_sched
  import uart_msg_pkg::*;
#(
  parameter int unsigned MSG_NUM    = 9,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_a_valid,
  input  logic [ID_W-1:0]   req_a_id,
  input  logic              req_b_valid,
  input  logic [ID_W-1:0]   req_b_id,
  input  logic              prio_b,
  input  logic              abort,
  input  logic              tx_busy,
  input  logic              tx_done,
  output logic              tx_start,
  output logic [BYTE_W-1:0] tx_data,
  output logic              sched_busy,
  output logic [ID_W-1:0]   last_id,
  output logic              ovf,
  output logic              bad_id
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [CNT_W-1:0]  w_count;
  logic [CNT_W-1:0]  w_free;
  logic [CNT_W-1:0]  w_count_nxt;
  logic [ID_W-1:0]   w_head;
  logic              w_a_bad, w_b_bad;
  cmd_req_t          w_req_a, w_req_b, w_first, w_second;
  logic              w_wr0_en, w_wr1_en;
  logic [ID_W-1:0]   w_wr0_data, w_wr1_data;
  logic              w_ovf_nxt, w_bad_nxt;
  logic              w_pop;

  state_e            r_state, w_state_nxt;
  logic [ID_W-1:0]   r_id, w_id_nxt;
  logic [IDX_W-1:0]  r_idx, w_idx_nxt;
  logic              r_abort_pend, w_abort_pend_nxt;
  logic              w_tx_start_nxt;
  logic [BYTE_W-1:0] w_tx_data_nxt;
  logic [ID_W-1:0]   w_last_id_nxt;
  logic              w_unused_tx_busy;

  assign w_unused_tx_busy = tx_busy;

  msg_cmd_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (ID_W)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_flush    (abort),
    .i_wr0_en   (w_wr0_en),
    .i_wr0_data (w_wr0_data),
    .i_wr1_en   (w_wr1_en),
    .i_wr1_data (w_wr1_data),
    .i_pop      (w_pop),
    .o_head_c   (w_head),
    .o_count    (w_count)
  );

  // Validate, order by priority and decide which requests fit. Room is
  // judged on the registered count only; a same-cycle pop does not help.
  always_comb begin
    w_a_bad       = req_a_valid && (32'(req_a_id) >= MSG_NUM);
    w_b_bad       = req_b_valid && (32'(req_b_id) >= MSG_NUM);
    w_req_a.valid = req_a_valid && !w_a_bad && !abort;
    w_req_a.id    = req_a_id;
    w_req_b.valid = req_b_valid && !w_b_bad && !abort;
    w_req_b.id    = req_b_id;
    w_first       = prio_b ? w_req_b : w_req_a;
    w_second      = prio_b ? w_req_a : w_req_b;
    w_free        = CNT_W'(FIFO_DEPTH) - w_count;

    w_wr0_en   = 1'b0;
    w_wr1_en   = 1'b0;
    w_wr0_data = w_first.id;
    w_wr1_data = w_second.id;
    w_ovf_nxt  = 1'b0;
    if (w_first.valid && w_second.valid) begin
      w_wr0_en  = (w_free != '0);
      w_wr1_en  = (w_free >= CNT_W'(2));
      w_ovf_nxt = (w_free < CNT_W'(2));
    end else if (w_first.valid || w_second.valid) begin
      w_wr0_en   = (w_free != '0);
      w_wr0_data = w_first.valid ? w_first.id : w_second.id;
      w_ovf_nxt  = (w_free == '0);
    end
    w_bad_nxt = (w_a_bad || w_b_bad) && !abort;
  end

  // Frame sequencing: next state and registered-output next values
  always_comb begin
    w_state_nxt      = r_state;
    w_id_nxt         = r_id;
    w_idx_nxt        = r_idx;
    w_abort_pend_nxt = r_abort_pend;
    w_pop            = 1'b0;
    w_tx_start_nxt   = 1'b0;
    w_tx_data_nxt    = tx_data;
    w_last_id_nxt    = last_id;
    case (r_state)
      IDLE: begin
        w_abort_pend_nxt = 1'b0;
        if (!abort && (w_count != '0)) begin
          w_pop       = 1'b1;
          w_id_nxt    = w_head;
          w_idx_nxt   = '0;
          w_state_nxt = LOAD;
        end
      end
      LOAD: begin
        if (abort) begin
          w_state_nxt = IDLE;
        end else begin
          // tx_start is registered here so it is high during SEND
          w_tx_data_nxt  = frame_byte(r_id, r_idx);
          w_tx_start_nxt = 1'b1;
          w_state_nxt    = SEND;
        end
      end
      SEND: begin
        if (abort) w_abort_pend_nxt = 1'b1;
        w_state_nxt = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (abort) w_abort_pend_nxt = 1'b1;
        if (tx_done) begin
          if (r_abort_pend || abort) begin
            w_state_nxt = IDLE;
          end else if (r_idx != IDX_W'(FRAME_LEN - 1)) begin
            w_idx_nxt   = r_idx + IDX_W'(1);
            w_state_nxt = LOAD;
          end else begin
            w_last_id_nxt = r_id;
            w_state_nxt   = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    w_count_nxt = abort ? '0
                : w_count + CNT_W'(w_wr0_en) + CNT_W'(w_wr1_en) - CNT_W'(w_pop);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_id         <= '0;
      r_idx        <= '0;
      r_abort_pend <= 1'b0;
      tx_start     <= 1'b0;
      tx_data      <= '0;
      sched_busy   <= 1'b0;
      last_id      <= '0;
      ovf          <= 1'b0;
      bad_id       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_id         <= w_id_nxt;
      r_idx        <= w_idx_nxt;
      r_abort_pend <= w_abort_pend_nxt;
      tx_start     <= w_tx_start_nxt;
      tx_data      <= w_tx_data_nxt;
      sched_busy   <= (w_state_nxt != IDLE) || (w_count_nxt != '0);
      last_id      <= w_last_id_nxt;
      ovf          <= w_ovf_nxt;
      bad_id       <= w_bad_nxt;
    end
  end

endmodule
